// File: rtl/paddle_encoder_if.sv
// Pin/status bundle between the encoder front-end and the pong renderer.
// slave = paddle_encoder side, master = pin/centre source and position consumer.
interface paddle_encoder_if;
  logic       enc1a;
  logic       enc1b;
  logic       enc2a;
  logic       enc2b;
  logic       center;
  logic [5:0] p1y;
  logic [5:0] p2y;
  logic       p1_move;
  logic       p2_move;
  logic       err;

  modport master (
    output enc1a, enc1b, enc2a, enc2b, center,
    input  p1y, p2y, p1_move, p2_move, err
  );

  modport slave (
    input  enc1a, enc1b, enc2a, enc2b, center,
    output p1y, p2y, p1_move, p2_move, err
  );
endinterface

// File: rtl/paddle_encoder.sv
// Two quadrature encoders -> clamped paddle rows; `PADDLE_ACCEL_EN` enables 2-row steps.
// Latency: SYNC_STAGES + DEB_CYCLES + 1 edges from a stable pin change to p*y/p*_move.
// No backpressure: free-running, at most one move per channel per cycle.
module paddle_encoder #(
  parameter int unsigned Y_MIN        = 5,
  parameter int unsigned Y_MAX        = 58,
  parameter int unsigned Y_INIT       = 30,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEB_CYCLES   = 16,
  parameter int unsigned ACCEL_WINDOW = 64
) (
  input logic             clk,
  input logic             rst_n,
  paddle_encoder_if.slave bus
);
  localparam int unsigned DW     = $clog2(DEB_CYCLES + 1);
  localparam logic [6:0]  Y_MIN7 = 7'(Y_MIN);
  localparam logic [6:0]  Y_MAX7 = 7'(Y_MAX);

  if (SYNC_STAGES < 2 || DEB_CYCLES < 1 || ACCEL_WINDOW < 1 ||
      Y_MIN > Y_MAX || Y_MAX > 63 || Y_INIT < Y_MIN || Y_INIT > Y_MAX) begin : g_bad_params
    $error("paddle_encoder: illegal parameter set");
  end

  // Quadrature phase as a position on the 4-state ring: 00,01,11,10 -> 0,1,2,3.
  function automatic logic [1:0] gpos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  logic [3:0]      w_pin;
  logic [3:0]      w_filt;
  logic [1:0][5:0] w_y;
  logic [1:0]      w_move;
  logic [1:0]      w_illegal;
  logic            r_err;

  assign w_pin = {bus.enc2b, bus.enc2a, bus.enc1b, bus.enc1a};

  for (genvar p = 0; p < 4; p++) begin : g_pin
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_deb_cnt;
    logic                   r_filt;
    logic                   w_synced;

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_filt[p] = r_filt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync    <= '0;
        r_deb_cnt <= '0;
        r_filt    <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin[p]};
        if (w_synced == r_filt) begin
          r_deb_cnt <= '0;
        end else if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
          r_filt    <= w_synced;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [1:0] w_cur;
    logic [1:0] r_prev;
    logic [1:0] w_delta;
    logic       w_up;
    logic       w_dn;
    logic [6:0] w_step;
    logic [6:0] w_y7;
    logic [6:0] w_next;
    logic [5:0] r_y;
    logic       r_move;

    assign w_cur        = {w_filt[2*c], w_filt[2*c+1]};
    assign w_delta      = gpos(w_cur) - gpos(r_prev);
    assign w_up         = (w_delta == 2'd1);
    assign w_dn         = (w_delta == 2'd3);
    assign w_illegal[c] = (w_delta == 2'd2);
    assign w_y7         = {1'b0, r_y};
    assign w_y[c]       = r_y;
    assign w_move[c]    = r_move;

`ifdef PADDLE_ACCEL_EN
    localparam int unsigned GAP_W = $clog2(ACCEL_WINDOW + 1);
    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(ACCEL_WINDOW);
    logic [GAP_W-1:0] r_gap;
    logic             r_last_up;

    // Only consulted when w_up or w_dn is set, so equality means same direction.
    assign w_step = (r_gap < GAP_SAT && r_last_up == w_up) ? 7'd2 : 7'd1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_gap     <= GAP_SAT;
        r_last_up <= 1'b0;
      end else if (bus.center) begin
        r_gap <= GAP_SAT;
      end else if (w_up || w_dn) begin
        r_gap     <= '0;
        r_last_up <= w_up;
      end else if (r_gap != GAP_SAT) begin
        r_gap <= r_gap + 1'b1;
      end
    end
`else
    assign w_step = 7'd1;
`endif

    always_comb begin
      w_next = w_y7;
      if (w_up) begin
        w_next = (w_y7 < Y_MIN7 + w_step) ? Y_MIN7 : w_y7 - w_step;
      end else if (w_dn) begin
        w_next = (w_y7 + w_step > Y_MAX7) ? Y_MAX7 : w_y7 + w_step;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prev <= 2'b00;
        r_y    <= 6'(Y_INIT);
        r_move <= 1'b0;
      end else begin
        r_prev <= w_cur;
        if (bus.center) begin
          r_y    <= 6'(Y_INIT);
          r_move <= 1'b0;
        end else begin
          r_y    <= w_next[5:0];
          r_move <= (w_next != w_y7);
        end
      end
    end
  end

  // Illegal transitions latch the flag even on a centre cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (|w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign bus.p1y     = w_y[0];
  assign bus.p2y     = w_y[1];
  assign bus.p1_move = w_move[0];
  assign bus.p2_move = w_move[1];
  assign bus.err     = r_err;
endmodule

// File: tb/tb_paddle_encoder.sv
// Directed + random bench for paddle_encoder against an event-level reference model.
module tb_paddle_encoder;
  localparam int SYNC = 2, DEB = 4, YMIN = 5, YMAX = 58, YINIT = 30, AWIN = 64;
  localparam int STEP_HOLD = SYNC + DEB + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mv_cnt[2];
  int   tb_pos[2];
  int   base[2];
  int   POS[4] = '{0, 1, 3, 2};  // {a,b} -> ring position, and ring position -> {a,b}

  paddle_encoder_if bus ();

  paddle_encoder #(
    .Y_MIN(YMIN), .Y_MAX(YMAX), .Y_INIT(YINIT),
    .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .ACCEL_WINDOW(AWIN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int      m_y[2];
  bit      m_mv[2];
  bit      m_err;
  bit      m_filt[4];
  int      m_prev[2];
  int      m_run[4];
  bit      m_q[4][$];
  longint  m_cyc = 0;
  longint  m_tlast[2];
  bit      m_lastup[2];

  function automatic bit pin_val(int p);
    case (p)
      0: return bus.enc1a;
      1: return bus.enc1b;
      2: return bus.enc2a;
      default: return bus.enc2b;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_y[c] = YINIT; m_mv[c] = 1'b0; m_prev[c] = 0;
        m_tlast[c] = -1000000; m_lastup[c] = 1'b0;
      end
      for (int p = 0; p < 4; p++) begin
        m_filt[p] = 1'b0; m_run[p] = 0;
        m_q[p].delete();
        for (int k = 0; k < SYNC; k++) m_q[p].push_back(1'b0);
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        int cur, d, step, ny;
        bit up;
        cur = {30'd0, m_filt[2*c], m_filt[2*c+1]};
        d = (POS[cur] - POS[m_prev[c]] + 4) % 4;
        m_mv[c] = 1'b0;
        if (d == 2) m_err = 1'b1;
        if (bus.center) begin
          m_y[c] = YINIT;
          m_tlast[c] = -1000000;
        end else if (d == 1 || d == 3) begin
          up = (d == 1);
          step = 1;
`ifdef PADDLE_ACCEL_EN
          if (m_cyc - m_tlast[c] <= AWIN && m_lastup[c] == up) step = 2;
          m_tlast[c] = m_cyc;
          m_lastup[c] = up;
`endif
          ny = up ? m_y[c] - step : m_y[c] + step;
          if (ny < YMIN) ny = YMIN;
          if (ny > YMAX) ny = YMAX;
          m_mv[c] = (ny != m_y[c]);
          m_y[c] = ny;
        end
        m_prev[c] = cur;
      end
      for (int p = 0; p < 4; p++) begin
        bit s;
        s = m_q[p].pop_front();
        if (s != m_filt[p]) begin
          m_run[p]++;
          if (m_run[p] == DEB) begin m_filt[p] = s; m_run[p] = 0; end
        end else begin
          m_run[p] = 0;
        end
        m_q[p].push_back(pin_val(p));
      end
      m_cyc++;
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("p1y", int'(bus.p1y), m_y[0]);
    chk("p2y", int'(bus.p2y), m_y[1]);
    chk("p1_move", int'(bus.p1_move), int'(m_mv[0]));
    chk("p2_move", int'(bus.p2_move), int'(m_mv[1]));
    chk("err", int'(bus.err), int'(m_err));
    if (bus.p1_move) mv_cnt[0]++;
    if (bus.p2_move) mv_cnt[1]++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_enc(int ch, int pos);
    logic [1:0] ab;
    ab = 2'(POS[pos & 3]);
    tb_pos[ch] = pos & 3;
    if (ch == 0) begin bus.enc1a = ab[1]; bus.enc1b = ab[0]; end
    else         begin bus.enc2a = ab[1]; bus.enc2b = ab[0]; end
  endtask

  // dir +1: up (row decrements), -1: down, 2: illegal double-bit change
  task automatic enc_step(int ch, int dir, int hold);
    set_enc(ch, tb_pos[ch] + dir + 4);
    tick(hold);
  endtask

  initial begin
    mv_cnt = '{0, 0};
    tb_pos = '{0, 0};
    bus.enc1a = 0; bus.enc1b = 0; bus.enc2a = 0; bus.enc2b = 0; bus.center = 0;
    tick(3);
    rst_n = 1'b1;
    #1;
    chk("rst_p1y", int'(bus.p1y), 30);
    chk("rst_p2y", int'(bus.p2y), 30);
    chk("rst_err", int'(bus.err), 0);
    tick(2);

    // single up step: exact latency
    set_enc(0, 1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 6) chk("t2_before_lat", int'(bus.p1y), 30);
      if (k == 7) begin
        chk("t2_p1y_at_lat", int'(bus.p1y), 29);
        chk("t2_move_at_lat", int'(bus.p1_move), 1);
        chk("t2_model_p1y", m_y[0], 29);
      end
      if (k == 8) begin
        chk("t2_move_one_cycle", int'(bus.p1_move), 0);
        chk("t2_p2y", int'(bus.p2y), 30);
      end
    end
    #1;

    // glitch rejection
    base[1] = mv_cnt[1];
    bus.enc2a = 1; tick(3); bus.enc2a = 0; tick(12);
    chk("t3_glitch_p2y", int'(bus.p2y), 30);
    chk("t3_glitch_moves", mv_cnt[1] - base[1], 0);
    base[1] = mv_cnt[1];
    bus.enc2a = 1; tick(4); bus.enc2a = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_pulse_p2y", int'(bus.p2y), 31);
    #1;
    tick(10);
    chk("t3_pulse_back_p2y", int'(bus.p2y), 30);
    chk("t3_pulse_moves", mv_cnt[1] - base[1], 2);

    // recentre, then saturation both ways
    bus.center = 1; tick(1); bus.center = 0;
    chk("t4_center_p1y", int'(bus.p1y), 30);
    base[0] = mv_cnt[0];
    for (int i = 0; i < 30; i++) enc_step(0, -1, STEP_HOLD);
    chk("t4_sat_hi_p1y", int'(bus.p1y), 58);
    chk("t4_sat_hi_moves", mv_cnt[0] - base[0], 28);
    base[0] = mv_cnt[0];
    for (int i = 0; i < 60; i++) enc_step(0, 1, STEP_HOLD);
    chk("t4_sat_lo_p1y", int'(bus.p1y), 5);
    chk("t4_sat_lo_moves", mv_cnt[0] - base[0], 53);

    // illegal transition
    enc_step(0, 2, 10);
    chk("t5_err", int'(bus.err), 1);
    chk("t5_err_p1y", int'(bus.p1y), 5);

    // centre colliding with a decoded move on channel 2
    base[1] = mv_cnt[1];
    set_enc(1, tb_pos[1] + 1);
    tick(6);
    bus.center = 1; tick(1); bus.center = 0;
    chk("t5_ctr_p1y", int'(bus.p1y), 30);
    chk("t5_ctr_p2y", int'(bus.p2y), 30);
    chk("t5_ctr_p2move", int'(bus.p2_move), 0);
    tick(3);
    chk("t5_ctr_moves", mv_cnt[1] - base[1], 0);
    chk("t5_err_sticky", int'(bus.err), 1);

    // asynchronous reset mid-run with pins toggling
    enc_step(0, 1, STEP_HOLD);
    for (int i = 0; i < 3; i++) begin
      bus.enc1a = 1'($urandom); bus.enc2b = 1'($urandom); tick(1);
    end
    #4;
    rst_n = 1'b0;
    #1;
    chk("t1_async_p1y", int'(bus.p1y), 30);
    chk("t1_async_p2y", int'(bus.p2y), 30);
    chk("t1_async_err", int'(bus.err), 0);
    set_enc(0, 0); set_enc(1, 0);
    tick(3);
    rst_n = 1'b1;
    base[0] = mv_cnt[0]; base[1] = mv_cnt[1];
    tick(9);
    chk("t1_quiet_moves1", mv_cnt[0] - base[0], 0);
    chk("t1_quiet_moves2", mv_cnt[1] - base[1], 0);

`ifdef PADDLE_ACCEL_EN
    enc_step(0, 1, 10);
    enc_step(0, 1, 10);
    chk("t6_fast_p1y", int'(bus.p1y), 27);
    bus.center = 1; tick(1); bus.center = 0;
    enc_step(0, 1, 70);
    enc_step(0, 1, 10);
    chk("t6_slow_p1y", int'(bus.p1y), 28);
`endif

    // random phase: mix of glitches, real steps, illegal jumps and centres
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.enc1a = ~bus.enc1a;
      if ($urandom_range(0, 15) == 0) bus.enc1b = ~bus.enc1b;
      if ($urandom_range(0, 15) == 0) bus.enc2a = ~bus.enc2a;
      if ($urandom_range(0, 15) == 0) bus.enc2b = ~bus.enc2b;
      bus.center = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    bus.center = 0;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/paddle_encoder.md
# paddle_encoder

Converts the two rotary quadrature encoders into clamped paddle row positions for the pong display. Sits directly upstream of the LED matrix renderer, which draws a 6-row paddle starting at the row given on `p1y`/`p2y`. Raw encoder pins are asynchronous and bouncy. This block synchronises them, filters glitches, decodes direction, and saturates each position to the drawable range.

## Interface
Parameters:
- `Y_MIN`, 5: lowest legal paddle row.
- `Y_MAX`, 58: highest legal paddle row.
- `Y_INIT`, 30: reset and recentre row.
- `SYNC_STAGES`, 2: flip-flops in the input synchroniser (≥2).
- `DEB_CYCLES`, 16: consecutive stable cycles required before a filtered input changes (≥1).
- `ACCEL_WINDOW`, 64: cycles used by the acceleration option.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enc1a`, `enc1b`  in  1 each: encoder 1 quadrature pins (async).
- `enc2a`, `enc2b`  in  1 each: encoder 2 quadrature pins (async).
- `center`  in  1: synchronous pulse; recentres both paddles.
- `p1y`, `p2y`  out  6: paddle top row, always within [Y_MIN, Y_MAX].
- `p1_move`, `p2_move`  out  1: one-cycle pulse when the matching position changes.
- `err`  out  1: sticky flag for an illegal quadrature transition; cleared only by reset.

## Operation
Each of the two channels is independent and identical.
- **Synchroniser:** a `SYNC_STAGES`-deep flip-flop chain per pin.
- **Debounce:** one counter per pin.
  - Counter clears while the synced value equals the filtered value.
  - Counter increments while they differ.
  - When the counter reaches `DEB_CYCLES`, the filtered value takes the synced value and the counter clears.
- **Decode:** compares previous and current filtered {a,b} each cycle.
  - Sequence 00→01→11→10→00 means up: y decrements by the step.
  - Reverse sequence means down: y increments by the step.
  - No change: no action.
  - Both bits changed (00↔11, 01↔10): no movement; `err` is set.
- **Step:** 1 row (see Configuration).
- **Saturation:** the computed next y is clamped to [Y_MIN, Y_MAX].
  - Computation is done in 7 bits, so there is no wrap-around.
  - A move into a bound that leaves y unchanged does not pulse `p*_move`.
- **Priority, highest first:** `rst_n` low, then `center`, then decoded move.
  - `center` high sets both y to Y_INIT on the next edge and discards that cycle's moves.
  - `center` does not pulse `p*_move`.
- **Reset (async assert):**
  - Outputs: `p1y` = `p2y` = Y_INIT, `p*_move` = 0, `err` = 0.
  - Internal state: synchroniser flops, filtered values and previous-state registers = 00; debounce counters = 0.
  - Reset mid-debounce discards the pending change.
  - Deassert is synchronous to `clk`; the first decode happens no earlier than the first edge after deassert.

## Timing
- **Latency:** a pin change held stable arrives at the synchroniser output after `SYNC_STAGES` edges. The filtered value updates after `DEB_CYCLES` further edges. `p*y` and `p*_move` update on the next edge after that.
  - Total: `SYNC_STAGES` + `DEB_CYCLES` + 1 edges from the first edge sampling the new level.
- **Bounce suppression:** any pulse shorter than `DEB_CYCLES` cycles at the synchroniser output produces no movement.
- **Move rate:** at most one move per channel per cycle.
- **Output registration:** `p*y`, `p*_move` and `err` are registered; there is no combinational path from any input to any output.

## Configuration
- **`PADDLE_ACCEL_EN` defined:** each channel keeps a saturating cycle counter since its last decoded move.
  - If a move occurs with the counter < `ACCEL_WINDOW` and in the same direction as the previous move, the step is 2 rows; otherwise 1.
  - Saturation still applies: y = Y_MIN+1 moving up by 2 gives Y_MIN.
  - The counter resets to saturated (slow) on reset and on `center`.
- **Not defined:** the step is always 1; the counter logic and `ACCEL_WINDOW` are unused.

## Test plan
Bench parameters: `DEB_CYCLES`=4, `SYNC_STAGES`=2, defaults otherwise.
1. **Reset:** hold `rst_n`=0 mid-run with pins toggling → `p1y`=`p2y`=30, `err`=0 asynchronously; no move within 7 edges after release with pins static.
2. **Single up step:** enc1 00→01 held → `p1y` 30→29 exactly 7 edges after the first sampling edge; `p1_move` high one cycle; `p2y` unchanged.
3. **Glitch rejection:** 3-cycle pulse on `enc2a` → `p2y` stays 30, no `p2_move`. A 4-cycle pulse → one move, then a reverse move when it drops.
4. **Saturation:** 30 down-transitions on enc1 → `p1y` stops at 58, with exactly 28 `p1_move` pulses. 60 up-transitions → stops at 5.
5. **Illegal transition and priority:**
   - enc1 00→11 in one step → `err`=1 sticky, `p1y` unchanged.
   - `center` coinciding with a decoded move → both y = 30, no `p*_move`.
6. **Acceleration (`PADDLE_ACCEL_EN`):**
   - Two same-direction moves 10 cycles apart → second step is 2 (30→29→27).
   - The same pair more than 64 cycles apart → steps of 1.
